// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered word count, registered status flags and an
// optional first-word-fall-through read port (FWFT_MODE=1).
module sync_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter bit FWFT_MODE    = 1'b0,
    parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
    localparam int CNT_WIDTH   = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_WIDTH-1:0]  data_cnt_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    (* ram_style = "block" *)
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_load;

    always_comb begin
        w_full   = (r_cnt == CNT_WIDTH'(FIFO_DEPTH));
        w_wr_acc = wr_en_i && !w_full;
        if (FWFT_MODE) begin
            w_empty  = !r_valid;
            w_rd_acc = rd_en_i && r_valid;
            // r_cnt counts the presented word too, so memory holds r_cnt - r_valid words;
            // refill the output register whenever it is free or being popped.
            w_load   = (r_cnt != CNT_WIDTH'(r_valid)) && (!r_valid || w_rd_acc);
        end else begin
            w_empty  = (r_cnt == '0);
            w_rd_acc = rd_en_i && !w_empty;
            w_load   = w_rd_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_data   <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en_i && w_full;
            r_underflow <= rd_en_i && w_empty;

            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end

            if (w_load) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
            end

            if (w_load) begin
                r_valid <= 1'b1;
            end else if (w_rd_acc) begin
                r_valid <= 1'b0;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + CNT_WIDTH'(1);
                2'b01:   r_cnt <= r_cnt - CNT_WIDTH'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rd_data_o      = r_rd_data;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_cnt >= CNT_WIDTH'(AFULL_LEVEL));
    assign almost_empty_o = (r_cnt <= CNT_WIDTH'(AEMPTY_LEVEL));
    assign data_cnt_o     = r_cnt;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: one standard-mode and one FWFT-mode instance
// driven by directed and random traffic, compared every cycle against queue models.
module tb_sync_fifo;

    localparam int DEPTH = 16;

    typedef struct {
        logic [7:0] d;
        int         t;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       sWrEn = 1'b0, sRdEn = 1'b0;
    logic [7:0] sWrData = '0;
    logic [7:0] sRdData;
    logic       sFull, sEmpty, sAfull, sAempty, sOvf, sUnd;
    logic [4:0] sCnt;

    logic       fWrEn = 1'b0, fRdEn = 1'b0;
    logic [7:0] fWrData = '0;
    logic [7:0] fRdData;
    logic       fFull, fEmpty, fAfull, fAempty, fOvf, fUnd;
    logic [4:0] fCnt;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    logic [7:0] qS[$];
    logic [7:0] expRdS = '0;
    bit         expOvfS = 1'b0, expUndS = 1'b0;

    entry_t     qF[$];
    entry_t     tmpE;
    bit         validF = 1'b0;
    bit         expOvfF = 1'b0, expUndF = 1'b0;
    int         cyc = 0;
    bit         ra, wa;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT_MODE(1'b0)) dutStd (
        .clk_i(clk), .rst_i(rst), .wr_en_i(sWrEn), .wr_data_i(sWrData), .rd_en_i(sRdEn),
        .rd_data_o(sRdData), .full_o(sFull), .empty_o(sEmpty), .almost_full_o(sAfull),
        .almost_empty_o(sAempty), .data_cnt_o(sCnt), .overflow_o(sOvf), .underflow_o(sUnd)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT_MODE(1'b1)) dutFwft (
        .clk_i(clk), .rst_i(rst), .wr_en_i(fWrEn), .wr_data_i(fWrData), .rd_en_i(fRdEn),
        .rd_data_o(fRdData), .full_o(fFull), .empty_o(fEmpty), .almost_full_o(fAfull),
        .almost_empty_o(fAempty), .data_cnt_o(fCnt), .overflow_o(fOvf), .underflow_o(fUnd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit sw, input logic [7:0] sd, input bit sr,
                                 input bit fw, input logic [7:0] fd, input bit fr);
        sWrEn = sw; sWrData = sd; sRdEn = sr;
        fWrEn = fw; fWrData = fd; fRdEn = fr;
        @(posedge clk);
        #1;
    endtask

    // Reference models: a plain word queue for standard mode; for FWFT each word
    // carries its write cycle, since it may only be presented from the following edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qS.delete();
            expRdS  = '0;
            expOvfS = 1'b0;
            expUndS = 1'b0;
            qF.delete();
            validF  = 1'b0;
            expOvfF = 1'b0;
            expUndF = 1'b0;
        end else begin
            ra      = sRdEn && (qS.size() > 0);
            wa      = sWrEn && (qS.size() < DEPTH);
            expOvfS = sWrEn && (qS.size() == DEPTH);
            expUndS = sRdEn && (qS.size() == 0);
            if (ra) expRdS = qS.pop_front();
            if (wa) qS.push_back(sWrData);

            ra      = fRdEn && validF;
            wa      = fWrEn && (qF.size() < DEPTH);
            expOvfF = fWrEn && (qF.size() == DEPTH);
            expUndF = fRdEn && !validF;
            if (ra) begin
                tmpE   = qF.pop_front();
                validF = 1'b0;
            end
            if (!validF && (qF.size() > 0) && (qF[0].t < cyc)) validF = 1'b1;
            if (wa) begin
                tmpE.d = fWrData;
                tmpE.t = cyc;
                qF.push_back(tmpE);
            end
            cyc++;
        end
    end

    // Compare every DUT output against the models on the falling edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("std_cnt",     32'(sCnt),    32'(qS.size()));
            checkOutput("std_full",    32'(sFull),   32'(qS.size() == DEPTH));
            checkOutput("std_empty",   32'(sEmpty),  32'(qS.size() == 0));
            checkOutput("std_afull",   32'(sAfull),  32'(qS.size() >= DEPTH - 2));
            checkOutput("std_aempty",  32'(sAempty), 32'(qS.size() <= 2));
            checkOutput("std_ovf",     32'(sOvf),    32'(expOvfS));
            checkOutput("std_und",     32'(sUnd),    32'(expUndS));
            checkOutput("std_rd_data", 32'(sRdData), 32'(expRdS));
            checkOutput("fwft_cnt",    32'(fCnt),    32'(qF.size()));
            checkOutput("fwft_full",   32'(fFull),   32'(qF.size() == DEPTH));
            checkOutput("fwft_empty",  32'(fEmpty),  32'(!validF));
            checkOutput("fwft_afull",  32'(fAfull),  32'(qF.size() >= DEPTH - 2));
            checkOutput("fwft_aempty", 32'(fAempty), 32'(qF.size() <= 2));
            checkOutput("fwft_ovf",    32'(fOvf),    32'(expOvfF));
            checkOutput("fwft_und",    32'(fUnd),    32'(expUndF));
            if (validF) checkOutput("fwft_rd_data", 32'(fRdData), 32'(qF[0].d));
        end
    end

    initial begin
        int  n;
        bit  w, r, fw, fr;
        int  pw, pr;

        repeat (2) @(posedge clk);
        #1;
        checkOn = 1'b1;
        checkOutput("rst_std_empty",  32'(sEmpty),  32'd1);
        checkOutput("rst_std_aempty", 32'(sAempty), 32'd1);
        checkOutput("rst_std_full",   32'(sFull),   32'd0);
        checkOutput("rst_std_afull",  32'(sAfull),  32'd0);
        checkOutput("rst_std_cnt",    32'(sCnt),    32'd0);
        checkOutput("rst_fwft_empty", 32'(fEmpty),  32'd1);
        checkOutput("rst_fwft_data",  32'(fRdData), 32'd0);
        rst = 1'b0;

        $display("[TB] standard fill");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
            if (i == 13) checkOutput("std_afull_at_13", 32'(sAfull), 32'd0);
            if (i == 14) checkOutput("std_afull_at_14", 32'(sAfull), 32'd1);
        end
        checkOutput("std_full_at_16", 32'(sFull), 32'd1);
        checkOutput("std_cnt_at_16",  32'(sCnt),  32'd16);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("std_ovf_pulse",    32'(sOvf), 32'd1);
        checkOutput("std_cnt_after_ovf", 32'(sCnt), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("std_ovf_cleared", 32'(sOvf), 32'd0);

        $display("[TB] standard drain");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
            checkOutput("std_drain_data", 32'(sRdData), 32'(i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("std_und_pulse", 32'(sUnd),    32'd1);
        checkOutput("std_und_hold",  32'(sRdData), 32'h10);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("std_und_cleared", 32'(sUnd), 32'd0);

        $display("[TB] simultaneous access");
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("sim_full_ovf",  32'(sOvf),    32'd1);
        checkOutput("sim_full_cnt",  32'(sCnt),    32'd15);
        checkOutput("sim_full_data", 32'(sRdData), 32'h21);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h9A, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("sim_mid_cnt", 32'(sCnt), 32'd8);
        checkOutput("sim_mid_ovf", 32'(sOvf), 32'd0);

        $display("[TB] fwft prefetch");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
        checkOutput("fwft_empty_after_wr", 32'(fEmpty), 32'd1);
        checkOutput("fwft_cnt_after_wr",   32'(fCnt),   32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("fwft_empty_2cyc", 32'(fEmpty),  32'd0);
        checkOutput("fwft_data_2cyc",  32'(fRdData), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("fwft_empty_after_rd", 32'(fEmpty), 32'd1);
        checkOutput("fwft_cnt_after_rd",   32'(fCnt),   32'd0);

        $display("[TB] wrap-around interleave");
        for (int k = 0; k < 40; k++) begin
            n = qS.size();
            if (n <= 5) begin
                w = 1'b1; r = 1'b0;
            end else if (n >= 12) begin
                w = 1'b0; r = 1'b1;
            end else begin
                w = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            fw = 1'($urandom_range(0, 1));
            fr = 1'($urandom_range(0, 1));
            applyStimulus(w, 8'($urandom), r, fw, 8'($urandom), fr);
        end

        $display("[TB] random traffic");
        for (int seg = 0; seg < 4; seg++) begin
            pw = (seg == 0) ? 80 : (seg == 1) ? 20 : (seg == 2) ? 60 : 50;
            pr = (seg == 0) ? 20 : (seg == 1) ? 80 : (seg == 2) ? 50 : 60;
            for (int k = 0; k < 100; k++) begin
                applyStimulus($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                              $urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
            end
        end

        $display("[TB] reset mid-operation");
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, i <= 7, 8'(8'h40 + i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("pre_rst_std_cnt",   32'(sCnt),    32'd7);
        checkOutput("pre_rst_std_data",  32'(sRdData), 32'h41);
        checkOutput("pre_rst_fwft_cnt",  32'(fCnt),    32'd7);
        checkOutput("pre_rst_fwft_data", 32'(fRdData), 32'h41);
        sRdEn = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_std_empty",  32'(sEmpty),  32'd1);
        checkOutput("async_rst_std_cnt",    32'(sCnt),    32'd0);
        checkOutput("async_rst_std_data",   32'(sRdData), 32'd0);
        checkOutput("async_rst_fwft_empty", 32'(fEmpty),  32'd1);
        checkOutput("async_rst_fwft_cnt",   32'(fCnt),    32'd0);
        checkOutput("async_rst_fwft_data",  32'(fRdData), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_std_data",  32'(sRdData), 32'h77);
        checkOutput("post_rst_fwft_data", 32'(fRdData), 32'h77);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_std_empty",  32'(sEmpty), 32'd1);
        checkOutput("post_rst_fwft_empty", 32'(fEmpty), 32'd1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other ports are synchronous to clk_i.
REQ-002 Parameter: DATA_WIDTH, 8, data word width in bits.
REQ-003 Parameter: FIFO_DEPTH, 16, number of entries; power of two, at least 4.
REQ-004 Parameter: FWFT_MODE, 1'b0, selects the read mode: 0 = standard read, 1 = first-word-fall-through.
REQ-005 Parameter: AFULL_LEVEL, FIFO_DEPTH-2, count at or above which almost_full_o is asserted.
REQ-006 Parameter: AEMPTY_LEVEL, 2, count at or below which almost_empty_o is asserted.
REQ-007 Derived: ADDR_WIDTH = clog2s(FIFO_DEPTH) from functions.vh; CNT_WIDTH = ADDR_WIDTH+1.
REQ-008 Port: clk_i  in  1  clock, all logic on the rising edge.
REQ-009 Port: rst_i  in  1  asynchronous reset, active high.
REQ-010 Port: wr_en_i  in  1  write request.
REQ-011 Port: wr_data_i  in  DATA_WIDTH  write data.
REQ-012 Port: rd_en_i  in  1  read request (pop).
REQ-013 Port: rd_data_o  out  DATA_WIDTH  registered read data.
REQ-014 Port: full_o  out  1  FIFO full.
REQ-015 Port: empty_o  out  1  no readable data.
REQ-016 Port: almost_full_o  out  1  count >= AFULL_LEVEL.
REQ-017 Port: almost_empty_o  out  1  count <= AEMPTY_LEVEL.
REQ-018 Port: data_cnt_o  out  CNT_WIDTH  number of words held, 0..FIFO_DEPTH.
REQ-019 Port: overflow_o  out  1  one-cycle pulse for a rejected write.
REQ-020 Port: underflow_o  out  1  one-cycle pulse for a rejected read.

Function
REQ-021 Storage SHALL be an unreset array marked ram_style "block"; write and read pointers SHALL be ADDR_WIDTH wide, wrapping from FIFO_DEPTH-1 to 0.
REQ-022 A write SHALL be accepted iff wr_en_i=1 and full_o=0; a write with full_o=1 SHALL be dropped even if a read occurs in the same cycle.
REQ-023 A read SHALL be accepted iff rd_en_i=1 and empty_o=0.
REQ-024 A simultaneous accepted read and write SHALL leave data_cnt_o unchanged and advance both pointers.
REQ-025 data_cnt_o SHALL be registered: +1 on a write-only cycle, -1 on a read-only cycle.
REQ-026 full_o SHALL equal (data_cnt_o == FIFO_DEPTH).
REQ-027 almost_full_o and almost_empty_o SHALL be decoded from the registered data_cnt_o.
REQ-028 Standard mode: rd_data_o SHALL present the head word on the edge after an accepted read (latency 1) and hold its value otherwise.
REQ-029 Standard mode: empty_o SHALL equal (data_cnt_o == 0); it deasserts one cycle after the first write into an empty FIFO.
REQ-030 FWFT mode: the head word SHALL be prefetched into rd_data_o, and rd_data_o SHALL be valid whenever empty_o=0.
REQ-031 FWFT mode: an accepted read SHALL pop the presented word and load the next word, if one exists, on the same edge.
REQ-032 FWFT mode: empty_o SHALL deassert two cycles after a write into an empty FIFO (memory write, then prefetch).
REQ-033 FWFT mode: data_cnt_o SHALL include the prefetched word.
REQ-034 overflow_o and underflow_o SHALL be registered, asserted for exactly one cycle after each rejected request.
REQ-035 Write-then-read ordering SHALL be preserved across pointer wrap-around with no lost or duplicated words.

Reset
REQ-036 While rst_i=1, the block SHALL clear both pointers, data_cnt_o, rd_data_o, overflow_o, underflow_o and the FWFT valid flag immediately.
REQ-037 During reset, empty_o=1, almost_empty_o=1, full_o=0 and almost_full_o=0; memory contents are not cleared.
REQ-038 Reset asserted mid-operation SHALL discard all stored words; after release the FIFO behaves as empty.

Verification
REQ-039 Standard mode, fill: write 0x01..0x10 (16 words) -> full_o=1 and data_cnt_o=16; almost_full_o rises when count reaches 14; a 17th write -> overflow_o pulses once and the count stays 16.
REQ-040 Standard mode, drain: read 16 times -> rd_data_o=0x01..0x10 in order, each one cycle after its rd_en_i; a 17th read -> underflow_o pulses, rd_data_o holds 0x10.
REQ-041 Wrap-around: run 40 interleaved writes and reads with count kept between 5 and 12 -> every read matches scoreboard order.
REQ-042 Simultaneous access: with count=16, assert wr_en_i and rd_en_i together -> the write is dropped, overflow_o pulses and the count becomes 15; with count=8, the same stimulus -> the count stays 8.
REQ-043 FWFT mode: write 0xA5 into an empty FIFO -> empty_o=0 and rd_data_o=0xA5 two cycles later with no rd_en_i; a read -> empty_o=1 the next cycle.
REQ-044 Reset mid-operation: with count=7, assert rst_i asynchronously -> empty_o=1, data_cnt_o=0 and rd_data_o=0 without a clock edge.
